// File: rtl/register_file.sv
// register_file: 31 x 32-bit RISC-V integer registers (x0 hard-wired to zero) with a
// post-reset initialisation sweep, two combinational read ports and write-to-read bypass.
`default_nettype none

module register_file #(
  parameter logic [31:0] SP_INIT = 32'h7FFF_EFFC,
  parameter logic [31:0] GP_INIT = 32'h1000_8000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Reg_Write_i,
  input  logic [4:0]  Write_Register_i,
  input  logic [31:0] Write_Data_i,
  input  logic [4:0]  Read_Register_1_i,
  input  logic [4:0]  Read_Register_2_i,
  output logic [31:0] Read_Data_1_o,
  output logic [31:0] Read_Data_2_o,
  output logic        Ready_o
);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic        ready_q;
  logic [31:0] regs_q [1:31];

  logic        wr_en;
  logic [4:0]  wr_idx;
  logic [31:0] wr_data;
  logic        user_wr;

  assign user_wr = Reg_Write_i && (Write_Register_i != 5'd0);

  // During CLEAR the sweep owns the single write port; user writes are dropped.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_en   = 1'b0;
    wr_idx  = idx_q;
    wr_data = 32'h0;
    if (state_q == CLEAR) begin
      wr_en = 1'b1;
      if (idx_q == 5'd2)      wr_data = SP_INIT;
      else if (idx_q == 5'd3) wr_data = GP_INIT;
      if (idx_q == 5'd31) state_d = READY;
      else                idx_d   = idx_q + 5'd1;
    end else if (user_wr) begin
      wr_en   = 1'b1;
      wr_idx  = Write_Register_i;
      wr_data = Write_Data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      idx_q   <= 5'd1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= (state_d == READY);
      if (wr_en && (wr_idx != 5'd0)) regs_q[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    Read_Data_1_o = 32'h0;
    if ((state_q == READY) && (Read_Register_1_i != 5'd0)) begin
      if (user_wr && (Write_Register_i == Read_Register_1_i)) Read_Data_1_o = Write_Data_i;
      else                                                   Read_Data_1_o = regs_q[Read_Register_1_i];
    end
  end

  always_comb begin
    Read_Data_2_o = 32'h0;
    if ((state_q == READY) && (Read_Register_2_i != 5'd0)) begin
      if (user_wr && (Write_Register_i == Read_Register_2_i)) Read_Data_2_o = Write_Data_i;
      else                                                   Read_Data_2_o = regs_q[Read_Register_2_i];
    end
  end

  assign Ready_o = ready_q;

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
// tb_register_file: vector table, hand-written reset/sweep sequences and random traffic vs a model.
`default_nettype none

module tb_register_file;

  localparam logic [31:0] SP = 32'h7FFF_EFFC;
  localparam logic [31:0] GP = 32'h1000_8000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  rd = 5'd0;
  logic [31:0] wd = 32'h0;
  logic [4:0]  rs1 = 5'd0;
  logic [4:0]  rs2 = 5'd0;
  logic [31:0] q1, q2;
  logic        rdy;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] model [0:31];

  register_file #(.SP_INIT(SP), .GP_INIT(GP)) dut (
    .clk(clk), .reset(reset),
    .Reg_Write_i(we), .Write_Register_i(rd), .Write_Data_i(wd),
    .Read_Register_1_i(rs1), .Read_Register_2_i(rs2),
    .Read_Data_1_o(q1), .Read_Data_2_o(q2), .Ready_o(rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Architectural view after a completed sweep.
  task automatic model_init();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    model[2] = SP;
    model[3] = GP;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (we && rd == idx) return wd;
    return model[idx];
  endfunction

  task automatic model_write();
    if (we && rd != 5'd0) model[rd] = wd;
  endtask

  // Counts edges after reset release; Ready must rise exactly on edge 31.
  task automatic sweep(input string tag);
    for (int e = 1; e <= 31; e++) begin
      step();
      if (e >= 29) check({tag, "_ready"}, {31'h0, rdy}, (e == 31) ? 32'h1 : 32'h0);
      if (e == 15) begin
        check({tag, "_clear_rd1"}, q1, 32'h0);
        check({tag, "_clear_rd2"}, q2, 32'h0);
      end
    end
  endtask

  vec_t vecs [9];

  initial begin
    vecs[0] = '{1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 5'd0, 32'h0,         5'd5, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0, 32'h0,         32'h0};
    vecs[3] = '{1'b0, 5'd0, 32'h0,         5'd0, 5'd2, 32'h0,         SP};
    vecs[4] = '{1'b1, 5'd7, 32'hA5A5_A5A5, 5'd7, 5'd8, 32'hA5A5_A5A5, 32'h0};
    vecs[5] = '{1'b0, 5'd7, 32'h0,         5'd7, 5'd8, 32'hA5A5_A5A5, 32'h0};
    vecs[6] = '{1'b1, 5'd8, 32'h0000_0001, 5'd7, 5'd8, 32'hA5A5_A5A5, 32'h1};
    vecs[7] = '{1'b1, 5'd3, 32'h0000_CAFE, 5'd3, 5'd3, 32'h0000_CAFE, 32'h0000_CAFE};
    vecs[8] = '{1'b0, 5'd3, 32'h0000_5555, 5'd3, 5'd4, 32'h0000_CAFE, 32'h0};

    // Reset held for two edges.
    rs1 = 5'd2; rs2 = 5'd3;
    step(); step();
    check("reset_ready", {31'h0, rdy}, 32'h0);
    check("reset_rd1", q1, 32'h0);
    check("reset_rd2", q2, 32'h0);
    reset = 1'b0;
    sweep("sweep1");
    rs1 = 5'd1; rs2 = 5'd2; #1;
    check("init_x1", q1, 32'h0);
    check("init_x2", q2, SP);
    rs1 = 5'd3; rs2 = 5'd31; #1;
    check("init_x3", q1, GP);
    check("init_x31", q2, 32'h0);
    model_init();

    // Directed vectors: compare before the edge (bypass visible), then commit.
    for (int i = 0; i < 9; i++) begin
      we = vecs[i].we; rd = vecs[i].rd; wd = vecs[i].wd;
      rs1 = vecs[i].rs1; rs2 = vecs[i].rs2;
      #1;
      check($sformatf("vec%0d_rd1", i), q1, vecs[i].e1);
      check($sformatf("vec%0d_rd2", i), q2, vecs[i].e2);
      model_write();
      step();
    end

    // Reset pulse mid-sweep while a write to x4 is requested throughout.
    we = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;
    we = 1'b1; rd = 5'd4; wd = 32'h5; rs1 = 5'd4; rs2 = 5'd4;
    for (int e = 1; e <= 9; e++) step();
    reset = 1'b1;
    step();
    check("midsweep_ready", {31'h0, rdy}, 32'h0);
    reset = 1'b0;
    sweep("sweep2");
    we = 1'b0; #1;
    check("midsweep_x4", q1, 32'h0);
    rs2 = 5'd2; #1;
    check("midsweep_x2", q2, SP);
    model_init();

    // Reset from READY discards contents and restarts the sweep.
    we = 1'b1; rd = 5'd9; wd = 32'hFFFF_FFFF;
    step();
    we = 1'b0; rs1 = 5'd9; rs2 = 5'd9; #1;
    check("x9_written", q1, 32'hFFFF_FFFF);
    reset = 1'b1;
    step();
    check("rst_ready_drop", {31'h0, rdy}, 32'h0);
    check("rst_rd1_zero", q1, 32'h0);
    check("rst_rd2_zero", q2, 32'h0);
    reset = 1'b0;
    sweep("sweep3");
    rs2 = 5'd2; #1;
    check("after_x9", q1, 32'h0);
    check("after_x2", q2, SP);
    model_init();

    // Random READY traffic.
    for (int c = 0; c < 1000; c++) begin
      we  = ($urandom_range(0, 3) != 0);
      rd  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      rs1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      rs2 = ($urandom_range(0, 3) == 0) ? rs1 : 5'($urandom_range(0, 31));
      #1;
      if (q1 !== model_read(rs1))
        check($sformatf("rand%0d_rd1", c), q1, model_read(rs1));
      else check("rand_rd1", q1, model_read(rs1));
      check($sformatf("rand%0d_rd2", c), q2, model_read(rs2));
      model_write();
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
